// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// ----------------
// Instruction-fetch stage for the pipelined core. It generates the fetch PC,
// keeps at most one request in flight to instruction memory, and buffers the
// returned instructions in a prefetch queue of QUEUE_DEPTH entries. The queue
// head is offered to the IF/ID boundary with a valid/ready handshake. Branch
// redirects flush the queue and discard any response still in flight. An HLT
// instruction stops fetching until the next redirect.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : a response arriving while the queue is empty is driven straight
//               to out_* in the same cycle. It is not stored if out_ready=1.
//   undefined : every response goes through the queue. out_valid rises the
//               cycle after imem_rvalid.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   imem_req        request strobe (memory accepts in the same cycle)
//   imem_addr       request address, zero when imem_req=0
//   imem_rvalid     response valid, at least one cycle after the request
//   imem_rdata      response instruction (opcode = top 4 bits)
//   redirect_valid  taken branch/jump; overrides everything else
//   redirect_pc     new fetch target
//   out_valid       queue head valid
//   out_ready       ID stage accepts the head (0 = stall)
//   out_instr       head instruction
//   out_pc          head instruction address
//   out_pc_next     out_pc + PC_STEP
//   halted          HLT fetched, no further requests
//   occupancy       number of entries held in the queue
module fetch_queue_unit #(
  parameter int               ADDR_W      = 16,
  parameter int               INSTR_W     = 16,
  parameter int               QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int               PC_STEP     = 2,
  parameter logic [3:0]       HLT_OPCODE  = 4'hF
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic                           imem_rvalid,
  input  logic [INSTR_W-1:0]             imem_rdata,
  input  logic                           redirect_valid,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INSTR_W-1:0]             out_instr,
  output logic [ADDR_W-1:0]              out_pc,
  output logic [ADDR_W-1:0]              out_pc_next,
  output logic                           halted,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [ADDR_W-1:0]   req_pc_q;
  logic                halted_q;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]    occ_q;
  logic [INSTR_W-1:0]  instr_mem [QUEUE_DEPTH];
  logic [ADDR_W-1:0]   pc_mem    [QUEUE_DEPTH];

  logic                issue;
  logic                rsp_accept;
  logic                rsp_is_hlt;
  logic                bypass;
  logic                push;
  logic                pop;
  logic                queue_empty;
  logic [INSTR_W-1:0]  head_instr;
  logic [ADDR_W-1:0]   head_pc;

  assign rsp_is_hlt  = (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);
  assign queue_empty = (occ_q == '0);

  // Next-state and request logic. The space rule counts the in-flight request
  // as an occupied slot, so a response can never arrive into a full queue.
  // In WAIT the completing request still counts, which is what lets a
  // latency-1 memory run at one instruction per cycle without overflow.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    rsp_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halted_q && (int'(occ_q) < QUEUE_DEPTH)) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          rsp_accept = 1'b1;
          if (rsp_is_hlt) begin
            state_d = HALT;
          end else if (int'(occ_q) + 1 < QUEUE_DEPTH) begin
            issue   = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A redirect kills any response arriving now. A request still in flight
    // has to be drained before new fetches can be matched to responses.
    if (redirect_valid) begin
      issue      = 1'b0;
      rsp_accept = 1'b0;
      if (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid) begin
        state_d = DRAIN;
      end else begin
        state_d = IDLE;
      end
    end
    if (rst) begin
      issue = 1'b0;
    end
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_accept && queue_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response consumed by ID in the same cycle never touches the
  // queue. Popping is only meaningful for real queue entries.
  assign push = rsp_accept && !(bypass && out_ready);
  assign pop  = !queue_empty && out_ready && !redirect_valid;

  assign head_instr = bypass ? imem_rdata : instr_mem[rd_ptr_q];
  assign head_pc    = bypass ? req_pc_q   : pc_mem[rd_ptr_q];

  assign out_valid   = !queue_empty || bypass;
  assign out_instr   = out_valid ? head_instr : '0;
  assign out_pc      = out_valid ? head_pc : '0;
  assign out_pc_next = out_valid ? (head_pc + ADDR_W'(PC_STEP)) : '0;
  assign imem_req    = issue;
  assign imem_addr   = issue ? fetch_pc_q : '0;
  assign halted      = halted_q;
  assign occupancy   = occ_q;

  // Fetch control: state, PC, and the address of the request in flight.
  // req_pc_q tags the response with its PC when it is written into the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        halted_q   <= 1'b0;
      end else begin
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_STEP);
          req_pc_q   <= fetch_pc_q;
        end
        if (rsp_accept && rsp_is_hlt) begin
          halted_q <= 1'b1;
        end
      end
    end
  end

  // Queue pointers and count. Pointers wrap naturally because QUEUE_DEPTH
  // is a power of two. A redirect empties the queue regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Queue storage needs no reset. Entries are only visible through out_*
  // while counted in occ_q, and out_* is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// -------------------
// Self-checking bench for fetch_queue_unit. A behavioural instruction memory
// answers each request after a configurable latency. Directed scenarios cover
// streaming, back-pressure, redirect, HLT, wrap and asynchronous reset. A
// randomized run compares every cycle against a transaction-level model
// built from a queue of expected entries.
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic        halted;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory model state
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0;
  int          due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        hlt_fixed = 1'b0;
  logic [15:0] hlt_addr = '0;
  logic        hlt_rand = 1'b0;

  // values seen in the most recent cycle
  logic        cur_pend, cur_rv;
  logic [15:0] cur_raddr, cur_rdata;
  logic        obs_req, obs_valid, obs_halted;
  logic [15:0] obs_addr, obs_instr, obs_pc, obs_pcn;
  logic [2:0]  obs_occ;

  fetch_queue_unit #(
    .ADDR_W(16), .INSTR_W(16), .QUEUE_DEPTH(DEPTH),
    .RESET_PC(16'h0000), .PC_STEP(2), .HLT_OPCODE(4'hF)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .halted(halted), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory contents: instruction = address >> 1, with optional HLT words.
  function automatic logic [15:0] instr_at(input logic [15:0] a);
    if (hlt_fixed && (a == hlt_addr)) return 16'hF000;
    if (hlt_rand && (a[5:1] == 5'd19)) return {4'hF, a[11:0]};
    return {1'b0, a[15:1]};
  endfunction

  // One clock cycle: called at posedge+1, drives inputs, samples outputs at
  // the negedge, lets the memory record any request, returns at posedge+1.
  task automatic tick(input logic redir, input logic [15:0] rpc, input logic rdy);
    cyc++;
    cur_pend  = pend;
    cur_rv    = pend && (cyc >= due);
    cur_raddr = pend_addr;
    cur_rdata = cur_rv ? instr_at(pend_addr) : 16'h0000;
    imem_rvalid    = cur_rv;
    imem_rdata     = cur_rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #4;
    obs_req    = imem_req;
    obs_addr   = imem_addr;
    obs_valid  = out_valid;
    obs_instr  = out_instr;
    obs_pc     = out_pc;
    obs_pcn    = out_pc_next;
    obs_halted = halted;
    obs_occ    = occupancy;
    if (cur_rv) pend = 1'b0;
    if (obs_req) begin
      pend      = 1'b1;
      pend_addr = obs_addr;
      due       = cyc + lat_min + int'($urandom_range(lat_max - lat_min, 0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    pend           = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if ({out_instr, out_pc, out_pc_next} !== 48'h0) begin errors++; $display("[TB] FAIL reset_out: got %0h/%0h/%0h expected 0", out_instr, out_pc, out_pc_next); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] reqs[$];
    int          req_cyc[$];
    logic [15:0] pcs[$], pcns[$], ins[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      if (obs_req) begin reqs.push_back(obs_addr); req_cyc.push_back(cyc); end
      if (obs_valid) begin pcs.push_back(obs_pc); pcns.push_back(obs_pcn); ins.push_back(obs_instr); end
    end
    checks++;
    if (reqs.size() < 3 || pcs.size() < 3) begin
      errors++;
      $display("[TB] FAIL stream_count: got %0d reqs %0d outs expected >= 3 each", reqs.size(), pcs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (reqs[k] !== 16'(2 * k)) begin errors++; $display("[TB] FAIL stream_req_addr[%0d]: got %0h expected %0h", k, reqs[k], 2 * k); end
        checks++; if (req_cyc[k] !== req_cyc[0] + k) begin errors++; $display("[TB] FAIL stream_req_cycle[%0d]: got %0d expected %0d", k, req_cyc[k], req_cyc[0] + k); end
        checks++; if (pcs[k] !== 16'(2 * k)) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %0h expected %0h", k, pcs[k], 2 * k); end
        checks++; if (pcns[k] !== 16'(2 * k + 2)) begin errors++; $display("[TB] FAIL stream_pc_next[%0d]: got %0h expected %0h", k, pcns[k], 2 * k + 2); end
        checks++; if (ins[k] !== 16'(k)) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %0h expected %0h", k, ins[k], k); end
      end
    end
  endtask

  task automatic test_backpressure();
    int          nreq = 0;
    logic [15:0] pcs[$];
    logic        got_req = 1'b0;
    logic [15:0] first_req = '0;
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 16'h0, 1'b0);
      if (obs_req) nreq++;
    end
    checks++; if (nreq !== DEPTH) begin errors++; $display("[TB] FAIL bp_requests: got %0d expected %0d", nreq, DEPTH); end
    checks++; if (obs_occ !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL bp_occupancy: got %0d expected %0d", obs_occ, DEPTH); end
    checks++; if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_idle: got %0b expected 0", obs_req); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      if (obs_valid) pcs.push_back(obs_pc);
      if (obs_req && !got_req) begin got_req = 1'b1; first_req = obs_addr; end
    end
    checks++;
    if (pcs.size() < 4) begin
      errors++;
      $display("[TB] FAIL bp_drain_count: got %0d expected >= 4", pcs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (pcs[k] !== 16'(2 * k)) begin errors++; $display("[TB] FAIL bp_drain_pc[%0d]: got %0h expected %0h", k, pcs[k], 2 * k); end
      end
    end
    checks++; if (!got_req || first_req !== 16'h0008) begin errors++; $display("[TB] FAIL bp_resume_addr: got %0h (seen %0b) expected 8", first_req, got_req); end
  endtask

  task automatic test_redirect();
    int          hs = 0;
    logic        found = 1'b0;
    logic        rdy;
    logic        got_req = 1'b0;
    logic        got_out = 1'b0;
    logic [15:0] first_req = '0;
    logic [15:0] first_pc = '0;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 40 && !found; i++) begin
      rdy = (hs < 2);
      tick(1'b0, 16'h0, rdy);
      if (obs_valid && rdy) hs++;
      if (obs_req && obs_addr == 16'h000A) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL redir_setup: request to 000a got 0 expected 1"); end
    tick(1'b1, 16'h0100, 1'b0);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_req: got %0b expected 0", obs_req); end
    checks++; if (obs_occ !== 3'd3) begin errors++; $display("[TB] FAIL redir_pre_occ: got %0d expected 3", obs_occ); end
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush_valid: got %0b expected 0", obs_valid); end
    checks++; if (obs_occ !== 3'd0) begin errors++; $display("[TB] FAIL redir_flush_occ: got %0d expected 0", obs_occ); end
    checks++; if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_drain_req: got %0b expected 0", obs_req); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      if (obs_req && !got_req) begin got_req = 1'b1; first_req = obs_addr; end
      if (obs_valid && !got_out) begin got_out = 1'b1; first_pc = obs_pc; end
    end
    checks++; if (!got_req || first_req !== 16'h0100) begin errors++; $display("[TB] FAIL redir_new_addr: got %0h expected 100", first_req); end
    checks++; if (!got_out || first_pc !== 16'h0100) begin errors++; $display("[TB] FAIL redir_first_pc: got %0h expected 100", first_pc); end
  endtask

  task automatic test_halt();
    int          nreq = 0;
    logic [15:0] last_req = '0;
    logic [15:0] pcs[$], ins[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    hlt_fixed = 1'b1; hlt_addr = 16'h0006;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      if (obs_req) begin nreq++; last_req = obs_addr; end
      if (obs_valid) begin pcs.push_back(obs_pc); ins.push_back(obs_instr); end
    end
    checks++; if (nreq !== 4 || last_req !== 16'h0006) begin errors++; $display("[TB] FAIL halt_requests: got %0d last %0h expected 4 last 6", nreq, last_req); end
    checks++; if (obs_halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %0b expected 1", obs_halted); end
    checks++;
    if (pcs.size() !== 4) begin
      errors++;
      $display("[TB] FAIL halt_deliveries: got %0d expected 4", pcs.size());
    end else begin
      checks++; if (pcs[3] !== 16'h0006 || ins[3] !== 16'hF000) begin errors++; $display("[TB] FAIL halt_last_entry: got %0h@%0h expected f000@6", ins[3], pcs[3]); end
    end
    tick(1'b1, 16'h0020, 1'b1);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_redir_req: got %0b expected 0", obs_req); end
    tick(1'b0, 16'h0, 1'b1);
    checks++; if (obs_halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_cleared: got %0b expected 0", obs_halted); end
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0020) begin errors++; $display("[TB] FAIL halt_resume: got req %0b addr %0h expected 1 addr 20", obs_req, obs_addr); end
    hlt_fixed = 1'b0;
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    lat_min = 1; lat_max = 1;
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rr_first_req: got %0b/%0h expected 1/0", obs_req, obs_addr); end
    tick(1'b1, 16'h0040, 1'b0);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL rr_no_req: got %0b expected 0", obs_req); end
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_occ !== 3'd0 || obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_dropped: got occ %0d valid %0b expected 0/0", obs_occ, obs_valid); end
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0040) begin errors++; $display("[TB] FAIL rr_next_req: got %0b/%0h expected 1/40", obs_req, obs_addr); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    lat_min = 1; lat_max = 1;
    tick(1'b1, 16'hFFFE, 1'b0);
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_req_fffe: got %0b/%0h expected 1/fffe", obs_req, obs_addr); end
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_req_0: got %0b/%0h expected 1/0", obs_req, obs_addr); end
    tick(1'b0, 16'h0, 1'b0);
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 16'hFFFE || obs_pcn !== 16'h0000 || obs_instr !== 16'h7FFF) begin
      errors++; $display("[TB] FAIL wrap_head: got v%0b %0h@%0h next %0h expected v1 7fff@fffe next 0", obs_valid, obs_instr, obs_pc, obs_pcn);
    end
    // fetch is now waiting on the request to 0x0002 with two entries queued
    imem_rvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next, halted, occupancy} !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got req %0b addr %0h v %0b %0h@%0h next %0h h %0b occ %0d expected all 0",
        imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next, halted, occupancy);
    end
    pend = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b0, 16'h0, 1'b1);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_restart: got %0b/%0h expected 1/0", obs_req, obs_addr); end
  endtask

  // Randomized run against a transaction-level model: expected entries are a
  // queue of {pc, instr}, the expected request stream is a running address.
  task automatic test_random();
    ent_t        q[$];
    ent_t        head;
    logic        halted_m = 1'b0;
    logic        pend_stale = 1'b0;
    logic [15:0] req_exp = 16'h0000;
    logic        redir, rdy, rsp_good, rsp_hlt, exp_valid, exp_req;
    logic [15:0] rpc;
    do_reset();
    lat_min = 1; lat_max = 3;
    hlt_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(15, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      rdy   = ($urandom_range(9, 0) < 7);
      tick(redir, rpc, rdy);
      rsp_good  = cur_rv && !pend_stale && !redir;
      rsp_hlt   = (cur_rdata[15:12] == 4'hF);
      exp_valid = (q.size() > 0) || (BYP && rsp_good);
      head      = (q.size() > 0) ? q[0] : '{pc: cur_raddr, instr: cur_rdata};
      if (!cur_pend) exp_req = !redir && !halted_m && (q.size() < DEPTH);
      else           exp_req = !redir && !halted_m && cur_rv && !pend_stale && !rsp_hlt && (q.size() + 1 < DEPTH);
      checks++; if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL rnd_req@%0d: got %0b expected %0b", cyc, obs_req, exp_req); end
      if (exp_req && obs_req) begin
        checks++; if (obs_addr !== req_exp) begin errors++; $display("[TB] FAIL rnd_addr@%0d: got %0h expected %0h", cyc, obs_addr, req_exp); end
      end
      checks++; if (obs_occ !== 3'(q.size())) begin errors++; $display("[TB] FAIL rnd_occ@%0d: got %0d expected %0d", cyc, obs_occ, q.size()); end
      checks++; if (obs_halted !== halted_m) begin errors++; $display("[TB] FAIL rnd_halted@%0d: got %0b expected %0b", cyc, obs_halted, halted_m); end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (obs_pc !== head.pc || obs_instr !== head.instr || obs_pcn !== head.pc + 16'd2) begin
          errors++; $display("[TB] FAIL rnd_head@%0d: got %0h@%0h next %0h expected %0h@%0h next %0h",
            cyc, obs_instr, obs_pc, obs_pcn, head.instr, head.pc, head.pc + 16'd2);
        end
      end
      if (redir) begin
        q.delete();
        halted_m   = 1'b0;
        req_exp    = rpc;
        pend_stale = cur_pend && !cur_rv;
      end else begin
        if (rsp_good) begin
          q.push_back('{pc: cur_raddr, instr: cur_rdata});
          if (rsp_hlt) halted_m = 1'b1;
        end
        if (exp_valid && rdy && q.size() > 0) void'(q.pop_front());
        if (cur_rv) pend_stale = 1'b0;
        if (obs_req) req_exp = req_exp + 16'd2;
      end
      if (obs_req) pend_stale = 1'b0;
    end
    hlt_rand = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    $display("[TB] starting fetch_queue_unit bench");
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_rvalid();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage for the pipelined core. It generates the PC, issues one request at a time to instruction memory, and buffers returned instructions in a prefetch queue of QUEUE_DEPTH entries. It presents entries to the IF/ID boundary with a valid/ready handshake. It handles branch redirect with flush, discard of in-flight responses, and stop-on-HLT, replacing the fixed single-slot IF logic.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction width (opcode = top 4 bits)
QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, PC loaded at reset
PC_STEP, 2, PC increment per instruction
HLT_OPCODE, 4'hF, opcode that stops fetching

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  request strobe; memory accepts in the same cycle
imem_addr  out  ADDR_W  request address, valid when imem_req=1
imem_rvalid  in  1  response valid, >= 1 cycle after the request
imem_rdata  in  INSTR_W  response instruction
redirect_valid  in  1  branch/jump taken, highest priority
redirect_pc  in  ADDR_W  new fetch target
out_valid  out  1  queue head valid
out_ready  in  1  ID stage can accept (0 = stall)
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head instruction address
out_pc_next  out  ADDR_W  out_pc + PC_STEP (for PCS)
halted  out  1  HLT fetched; no further requests
occupancy  out  clog2(QUEUE_DEPTH)+1  entries in queue

Behaviour:
- Reset: asynchronous, active-high on rst.
- Reset values: fetch_pc=RESET_PC; queue empty; occupancy=0; out_valid=0; imem_req=0; halted=0; state=IDLE. All other outputs are 0.
- State IDLE:
  - Asserts imem_req with imem_addr=fetch_pc when !halted, !redirect_valid and occupancy + outstanding < QUEUE_DEPTH.
  - On issue: fetch_pc += PC_STEP (mod 2^ADDR_W); go to WAIT.
- State WAIT (one outstanding request):
  - On imem_rvalid: push {rdata, pc} into the queue.
  - If rdata opcode == HLT_OPCODE: set halted, go to HALT. The HLT itself is queued.
  - Otherwise: go to IDLE. The next request may issue in the same cycle as rvalid if the space rule holds, so latency-1 memory sustains 1 instr/cycle.
- State HALT: no requests. Queue continues to drain. Exits only via redirect or reset.
- State DRAIN: waits for the stale response. On imem_rvalid: discard the response, go to IDLE.
- Redirect (any state):
  - Queue flushed in that cycle; out_valid=0 from the next cycle.
  - fetch_pc=redirect_pc; halted cleared; no request issued in the redirect cycle.
  - Request outstanding and rvalid not present this cycle -> DRAIN.
  - rvalid present the same cycle -> response discarded, go to IDLE.
  - Redirect while in DRAIN: stay in DRAIN with the new fetch_pc.
- Queue:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: occupancy unchanged.
  - Pointers wrap mod QUEUE_DEPTH.
  - Push never occurs when full; guaranteed by the issue rule.
  - Redirect overrides both push and pop.
- out_* always reflect the queue head. Head fields hold stable while out_valid & !out_ready.
- imem_rvalid in IDLE/HALT is a protocol error and is ignored.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty (or popped empty this cycle) and a non-discarded response arrives, it is driven combinationally to out_* with out_valid=1 in the same cycle.
  - If out_ready=1 that cycle, it is not written into the queue.
  - Fetch-to-ID latency 0 cycles.
- Undefined: every response goes through the queue; out_valid rises the cycle after rvalid.

Test Plan:
1. Reset, RESET_PC=0, latency-1 memory returning addr>>1, out_ready=1 -> requests at 0x0000, 0x0002, 0x0004 on consecutive cycles; out_pc 0,2,4; out_pc_next 2,4,6.
2. out_ready=0 from reset, DEPTH=4 -> exactly 4 requests issued; occupancy=4; imem_req stays 0. Raise out_ready -> entries in order 0,2,4,6, then fetch resumes at 0x0008.
3. redirect_valid with redirect_pc=0x0100 while request to 0x000A is outstanding and 3 entries are queued -> next cycle out_valid=0; stale 0x000A response discarded; next request addr=0x0100.
4. Response 0xF000 at pc 0x0006 -> halted=1; no further imem_req; HLT entry delivered last. Redirect to 0x0020 -> halted=0, fetch at 0x0020.
5. Redirect coincident with imem_rvalid -> response dropped; occupancy=0 next cycle; no request that cycle.
6. fetch_pc=0xFFFE -> next request address 0x0000 (wrap). Assert rst mid-WAIT -> all outputs return to reset values immediately.
